sobel_window_gen: RTL and testbench

Upstream neighbour of sobel_module. Takes a raster-order 8-bit greyscale pixel stream and builds the 3x3 neighbourhood that sobel_module consumes on p0..p8. It uses two line buffers and a 3x3 register window. One registered window is emitted per accepted pixel once the window is fully inside the frame.

---
 rtl/sobel_window_gen.sv | 120 ++++++++++++
 tb/tb_sobel_window_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream -> registered 3x3 window; 1 cycle accept-to-window, no backpressure.
// Define SOBEL_WIN_CENTRE_EN to expose the window centre pixel on port p4.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] p0,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
`ifdef SOBEL_WIN_CENTRE_EN
  output logic [7:0] p4,
`endif
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
  output logic       win_valid,
  output logic       frame_end
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_p0, r_p1, r_p2, r_p3, r_p4, r_p5, r_p6, r_p7, r_p8;
  logic          r_win_valid;
  logic          r_frame_end;

  // Line buffers are column-addressed rings: reading slot col before overwriting
  // it yields the pixel from exactly one (lb0) or two (lb1) lines above.
  logic [7:0]    r_lb0 [IMG_WIDTH];
  logic [7:0]    r_lb1 [IMG_WIDTH];

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last_col;
  logic          w_last_row;
  logic [7:0]    w_lb0_out;
  logic [7:0]    w_lb1_out;

  // sof forces the current pixel to (0,0) whatever the counters hold.
  assign w_col      = sof ? '0 : r_col;
  assign w_row      = sof ? '0 : r_row;
  assign w_last_col = (w_col == C_LAST);
  assign w_last_row = (w_row == R_LAST);
  assign w_lb0_out  = r_lb0[w_col];
  assign w_lb1_out  = r_lb1[w_col];

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb0[w_col] <= pix_in;
      r_lb1[w_col] <= w_lb0_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_p3        <= '0;
      r_p4        <= '0;
      r_p5        <= '0;
      r_p6        <= '0;
      r_p7        <= '0;
      r_p8        <= '0;
      r_win_valid <= 1'b0;
      r_frame_end <= 1'b0;
    end else if (pix_valid) begin
      r_col <= w_last_col ? '0 : w_col + CW'(1);
      if (w_last_col) begin
        r_row <= w_last_row ? '0 : w_row + RW'(1);
      end else begin
        r_row <= w_row;
      end
      r_p0        <= r_p1;
      r_p1        <= r_p2;
      r_p2        <= w_lb1_out;
      r_p3        <= r_p4;
      r_p4        <= r_p5;
      r_p5        <= w_lb0_out;
      r_p6        <= r_p7;
      r_p7        <= r_p8;
      r_p8        <= pix_in;
      r_win_valid <= (w_row >= R_TWO) && (w_col >= C_TWO);
      r_frame_end <= w_last_col && w_last_row;
    end else begin
      r_win_valid <= 1'b0;
      r_frame_end <= 1'b0;
    end
  end

  assign p0        = r_p0;
  assign p1        = r_p1;
  assign p2        = r_p2;
  assign p3        = r_p3;
`ifdef SOBEL_WIN_CENTRE_EN
  assign p4        = r_p4;
`endif
  assign p5        = r_p5;
  assign p6        = r_p6;
  assign p7        = r_p7;
  assign p8        = r_p8;
  assign win_valid = r_win_valid;
  assign frame_end = r_frame_end;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x6 frame with pix_in = row*8+col.
module tb_sobel_window_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic       win_valid;
  logic       frame_end;
  logic [63:0] obs_win;

  int n_tests = 0;
  int n_fail  = 0;

  sobel_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p5        (p5),
    .p6        (p6),
    .p7        (p7),
    .p8        (p8),
    .win_valid (win_valid),
    .frame_end (frame_end)
  );

  assign obs_win = {p0, p1, p2, p3, p5, p6, p7, p8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Window whose bottom-right pixel is (r,c), packed p0,p1,p2,p3,p5,p6,p7,p8.
  function automatic logic [63:0] model_win(input int r, input int c);
    int b;
    b = (r - 2) * 8 + (c - 2);
    return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 8), 8'(b + 10), 8'(b + 16), 8'(b + 17), 8'(b + 18)};
  endfunction

  task automatic accept(input logic [7:0] v, input logic s);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = v;
    sof       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic run_frame(input logic first_sof, input logic gaps);
    int nwin;
    int nfe;
    int r;
    int c;
    logic exp_vld;
    nwin = 0;
    nfe  = 0;
    for (int idx = 0; idx < 48; idx++) begin
      r = idx / 8;
      c = idx % 8;
      exp_vld = (r >= 2) && (c >= 2);
      accept(8'(idx), (idx == 0) && first_sof);
      if (win_valid) nwin++;
      if (frame_end) nfe++;
      check("win_valid", 64'(win_valid), 64'(exp_vld));
      check("frame_end", 64'(frame_end), 64'(idx == 47));
      if (exp_vld) check("window", obs_win, model_win(r, c));
      if (r == 2 && c == 2) check("first_window", obs_win, 64'h0001_0208_0A10_1112);
      if (idx == 47) check("last_window", obs_win, 64'h1D1E_1F25_272D_2E2F);
      if (gaps) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          pix_valid = 1'b0;
          sof       = 1'b0;
          pix_in    = 8'hA5;
          @(posedge clk);
          #1;
          check("idle_win_valid", 64'(win_valid), 64'd0);
          check("idle_frame_end", 64'(frame_end), 64'd0);
          check("idle_p8_hold", 64'(p8), 64'(idx));
          if (exp_vld) check("idle_window_hold", obs_win, model_win(r, c));
        end
      end
    end
    check("windows_per_frame", 64'(nwin), 64'd24);
    check("frame_end_count", 64'(nfe), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_window", obs_win, 64'd0);
    check("reset_win_valid", 64'(win_valid), 64'd0);
    check("reset_frame_end", 64'(frame_end), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(1'b1, 1'b0);
    go_idle();
    run_frame(1'b1, 1'b1);
    go_idle();

    // Back-to-back frames; the second relies on counter wrap, not sof.
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);
    go_idle();

    // Abandon a frame with sof at (3,4).
    for (int idx = 0; idx < 28; idx++) begin
      accept(8'(idx + 100), idx == 0);
      check("partial_win_valid", 64'(win_valid), 64'((idx / 8 >= 2) && (idx % 8 >= 2)));
      check("partial_frame_end", 64'(frame_end), 64'd0);
    end
    run_frame(1'b1, 1'b0);
    go_idle();

    // Async reset while a window is being presented.
    for (int idx = 0; idx < 20; idx++) begin
      accept(8'(idx), idx == 0);
    end
    check("pre_reset_win_valid", 64'(win_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_window", obs_win, 64'd0);
    check("async_reset_win_valid", 64'(win_valid), 64'd0);
    check("async_reset_frame_end", 64'(frame_end), 64'd0);
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, 1'b0);
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
